// File: rtl/wave_nco.sv
// wave_nco: phase-accumulator NCO with quarter-wave sine ROM, wave shapers, amplitude scaling and half-wave split
module wave_nco #(
    parameter int PHASE_W = 24,
    parameter int LUT_AW  = 6,
    parameter int DATA_W  = 8,
    parameter int AMP_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sin_clk,
    input  logic [PHASE_W-1:0] ftw,
    input  logic               ftw_load,
    input  logic [1:0]         wave_sel,
    input  logic [AMP_W-1:0]   amp,
    input  logic               phase_clr,
    output logic [DATA_W-1:0]  pos_out,
    output logic [DATA_W-1:0]  neg_out,
    output logic               sample_valid,
    output logic               wrap
);
    // Only the top phase bits feed the shapers; lower bits matter only for the accumulator.
    localparam int  TOP_W = 2 + (DATA_W > LUT_AW ? DATA_W : LUT_AW);
    localparam real PI    = 3.14159265358979323846;

    logic [PHASE_W-1:0] acc_q, acc_d, ftw_q;
    logic [PHASE_W:0]   sum;
    logic               wrap_q, wrap_d;

    logic               s1_v_q;
    logic [TOP_W-1:0]   s1_p_q;
    logic [1:0]         s1_sel_q;
    logic [AMP_W-1:0]   s1_amp_q;

    logic               s2_v_q, s2_neg_q;
    logic [DATA_W-1:0]  s2_mag_q;
    logic [AMP_W-1:0]   s2_amp_q;

    logic               valid_q;
    logic [DATA_W-1:0]  pos_q, neg_q;

    logic [1:0]         q;
    logic [LUT_AW-1:0]  idx, addr;
    logic [DATA_W-1:0]  frac, saw, mag_d, scaled;
    logic [AMP_W:0]     amp1;
    logic [DATA_W+AMP_W-1:0] prod;
    logic               unused_lsb;

    logic [DATA_W-1:0]  rom [2**LUT_AW];

    // Quarter-wave table sampled at bin centres so the mirrored quadrants stay symmetric.
    for (genvar k = 0; k < 2**LUT_AW; k++) begin : g_rom
        assign rom[k] = DATA_W'($rtoi((2.0**DATA_W - 1.0) *
                        $sin(PI / 2.0 * (real'(k) + 0.5) / (2.0**LUT_AW)) + 0.5));
    end

    assign sum = {1'b0, acc_q} + {1'b0, ftw_q};

    // Next accumulator value; a clear wins over a tick and suppresses the wrap pulse.
    always_comb begin
        acc_d  = phase_clr ? '0 : sin_clk ? sum[PHASE_W-1:0] : acc_q;
        wrap_d = !phase_clr && sin_clk && sum[PHASE_W];
    end

    // Accumulator, tuning word and wrap flag; a load only affects later ticks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q  <= '0;
            ftw_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            wrap_q <= wrap_d;
            if (ftw_load) ftw_q <= ftw;
        end
    end

    // S1: snapshot the pre-update phase together with this sample's controls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_v_q   <= 1'b0;
            s1_p_q   <= '0;
            s1_sel_q <= '0;
            s1_amp_q <= '0;
        end else begin
            s1_v_q <= sin_clk;
            if (sin_clk) begin
                s1_p_q   <= acc_q[PHASE_W-1 -: TOP_W];
                s1_sel_q <= wave_sel;
                s1_amp_q <= amp;
            end
        end
    end

    assign q    = s1_p_q[TOP_W-1 -: 2];
    assign idx  = s1_p_q[TOP_W-3 -: LUT_AW];
    assign frac = s1_p_q[TOP_W-3 -: DATA_W];
    assign saw  = s1_p_q[TOP_W-2 -: DATA_W];
    assign addr = q[0] ? ~idx : idx;

    // Waveform magnitude; odd quadrants run the ROM and triangle backwards.
    always_comb begin
        mag_d = s1_sel_q == 2'd0 ? rom[addr] :
                s1_sel_q == 2'd1 ? (q[0] ? ~frac : frac) :
                s1_sel_q == 2'd2 ? {DATA_W{1'b1}} :
                                   (q[1] ? ~saw : saw);
    end

    // S2: registered ROM read / shaper result and half-wave polarity.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_v_q   <= 1'b0;
            s2_neg_q <= 1'b0;
            s2_mag_q <= '0;
            s2_amp_q <= '0;
        end else begin
            s2_v_q <= s1_v_q;
            if (s1_v_q) begin
                s2_mag_q <= mag_d;
                s2_neg_q <= q[1];
                s2_amp_q <= s1_amp_q;
            end
        end
    end

    assign amp1       = {1'b0, s2_amp_q} + (AMP_W+1)'(1);
    assign prod       = {{AMP_W{1'b0}}, s2_mag_q} * {{(DATA_W-1){1'b0}}, amp1};
    assign scaled     = prod[AMP_W +: DATA_W];
    assign unused_lsb = ^prod[AMP_W-1:0];

    // S3: scale and steer to one half-wave output; outputs hold between samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            pos_q   <= '0;
            neg_q   <= '0;
        end else begin
            valid_q <= s2_v_q;
            if (s2_v_q) begin
                pos_q <= s2_neg_q ? '0 : scaled;
                neg_q <= s2_neg_q ? scaled : '0;
            end
        end
    end

    assign pos_out      = pos_q;
    assign neg_out      = neg_q;
    assign sample_valid = valid_q;
    assign wrap         = wrap_q;
endmodule

// File: tb/tb_wave_nco.sv
// tb_wave_nco: directed and randomized checks of wave_nco against a behavioural phase/waveform model
module tb_wave_nco;
    logic        clk = 1'b0;
    logic        reset, sin_clk, ftw_load, phase_clr;
    logic [23:0] ftw;
    logic [1:0]  wave_sel;
    logic [7:0]  amp;
    logic [7:0]  pos_out, neg_out;
    logic        sample_valid, wrap;

    int checks = 0;
    int errors = 0;
    int m_acc, m_ftw;

    always #5 clk = ~clk;

    wave_nco dut (
        .clk(clk), .reset(reset), .sin_clk(sin_clk), .ftw(ftw), .ftw_load(ftw_load),
        .wave_sel(wave_sel), .amp(amp), .phase_clr(phase_clr), .pos_out(pos_out),
        .neg_out(neg_out), .sample_valid(sample_valid), .wrap(wrap)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Ideal waveform at phase p (24-bit), returned as {pos, neg}.
    function automatic logic [15:0] ref_out(input int p, input int sel, input int a);
        int  mag;
        bit  neg;
        real x;
        neg = p >= 32'h800000;
        case (sel)
            0: begin
                x = 255.0 * $sin(2.0 * 3.14159265358979323846 * (real'(p / 65536) + 0.5) / 256.0);
                if (x < 0.0) x = -x;
                mag = $rtoi(x + 0.5);
            end
            1: begin
                mag = (p / 16384) % 256;
                if ((p / 4194304) % 2 == 1) mag = 255 - mag;
            end
            2: mag = 255;
            default: begin
                mag = (p / 32768) % 256;
                if (neg) mag = 255 - mag;
            end
        endcase
        mag = mag * (a + 1) / 256;
        return neg ? {8'd0, 8'(mag)} : {8'(mag), 8'd0};
    endfunction

    // Phase seen by this tick and the carry it should produce; then advance the model.
    task automatic model_tick(input bit tick, input bit clr, input bit ld, input int f,
                              output int phase, output bit carry);
        phase = m_acc;
        carry = !clr && tick && (m_acc + m_ftw >= 32'h1000000);
        if (clr) m_acc = 0;
        else if (tick) m_acc = (m_acc + m_ftw) % 32'h1000000;
        if (ld) m_ftw = f;
    endtask

    task automatic setup(input int f, input int sel, input int a);
        sin_clk = 1'b0; ftw = 24'(f); ftw_load = 1'b1; phase_clr = 1'b1;
        wave_sel = 2'(sel); amp = 8'(a);
        step;
        ftw_load = 1'b0; phase_clr = 1'b0;
        step; step; step;
        m_acc = 0; m_ftw = f;
    endtask

    task automatic test_reset;
        reset = 1'b1; sin_clk = 1'b0; ftw_load = 1'b0; phase_clr = 1'b0;
        ftw = '0; wave_sel = '0; amp = '0;
        step; step;
        checks++; if (pos_out !== 8'd0) begin errors++; $display("FAIL reset_pos: got %0d expected 0", pos_out); end
        checks++; if (neg_out !== 8'd0) begin errors++; $display("FAIL reset_neg: got %0d expected 0", neg_out); end
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", sample_valid); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %0b expected 0", wrap); end
        reset = 1'b0;
        step;
    endtask

    task automatic test_square;
        int ep;
        setup(32'h400000, 2, 255);
        sin_clk = 1'b1;
        for (int s = 1; s <= 11; s++) begin
            step;
            if (s < 3) begin
                checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL square_latency s=%0d: got %0b expected 0", s, sample_valid); end
            end else begin
                ep = ((s - 3) % 4 < 2) ? 255 : 0;
                checks++;
                if (sample_valid !== 1'b1 || pos_out !== 8'(ep) || neg_out !== 8'(255 - ep)) begin
                    errors++;
                    $display("FAIL square n=%0d: got v=%0b pos=%0d neg=%0d expected v=1 pos=%0d neg=%0d",
                             s - 3, sample_valid, pos_out, neg_out, ep, 255 - ep);
                end
            end
        end
        sin_clk = 1'b0;
    endtask

    task automatic test_triangle;
        int tri_v [8] = '{0, 64, 128, 192, 255, 191, 127, 63};
        int n, ep, en;
        setup(32'h100000, 1, 255);
        sin_clk = 1'b1;
        for (int s = 1; s <= 18; s++) begin
            step;
            if (s >= 3) begin
                n  = s - 3;
                ep = n < 8 ? tri_v[n] : 0;
                en = n < 8 ? 0 : tri_v[n - 8];
                checks++;
                if (pos_out !== 8'(ep) || neg_out !== 8'(en)) begin
                    errors++;
                    $display("FAIL triangle n=%0d: got pos=%0d neg=%0d expected pos=%0d neg=%0d", n, pos_out, neg_out, ep, en);
                end
            end
        end
        sin_clk = 1'b0;
    endtask

    task automatic test_sine;
        logic [7:0]  ps [64];
        logic [7:0]  ns [64];
        logic [15:0] e;
        int peak, pk_ref, bad;
        setup(32'h040000, 0, 255);
        sin_clk = 1'b1;
        for (int s = 1; s <= 66; s++) begin
            step;
            if (s >= 3) begin
                ps[s - 3] = pos_out;
                ns[s - 3] = neg_out;
                e = ref_out((s - 3) * 32'h40000, 0, 255);
                checks++;
                if ({pos_out, neg_out} !== e) begin
                    errors++;
                    $display("FAIL sine n=%0d: got pos=%0d neg=%0d expected pos=%0d neg=%0d", s - 3, pos_out, neg_out, e[15:8], e[7:0]);
                end
            end
        end
        sin_clk = 1'b0;
        bad = 0;
        for (int n = 0; n < 32; n++) if (ns[n + 32] !== ps[n] || ps[n + 32] !== 8'd0 || ns[n] !== 8'd0) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL sine_halves: got %0d bad pairs expected 0", bad); end
        peak = 0;
        for (int n = 0; n < 64; n++) if (int'(ps[n]) > peak) peak = int'(ps[n]);
        pk_ref = $rtoi(255.0 * $sin(3.14159265358979323846 / 2.0 * 63.5 / 64.0) + 0.5);
        checks++; if (peak != pk_ref) begin errors++; $display("FAIL sine_peak: got %0d expected %0d", peak, pk_ref); end
    endtask

    task automatic test_amp;
        int a, e, ex;
        setup(0, 2, 255);
        sin_clk = 1'b1;
        for (int s = 1; s <= 10; s++) begin
            amp = s <= 2 ? 8'd255 : s <= 6 ? 8'd127 : 8'd0;
            step;
            if (s >= 3) begin
                e  = s - 2;
                a  = e <= 2 ? 255 : e <= 6 ? 127 : 0;
                ex = 255 * (a + 1) / 256;
                checks++;
                if (pos_out !== 8'(ex) || neg_out !== 8'd0) begin
                    errors++;
                    $display("FAIL amp edge=%0d: got pos=%0d neg=%0d expected pos=%0d neg=0", e, pos_out, neg_out, ex);
                end
            end
        end
        sin_clk = 1'b0; amp = 8'd255;
    endtask

    task automatic test_wrap_clear;
        int ph [10];
        int p;
        bit c;
        logic [15:0] e;
        setup(32'h800000, 2, 255);
        sin_clk = 1'b1;
        for (int s = 1; s <= 9; s++) begin
            phase_clr = (s == 6);
            model_tick(1'b1, phase_clr, 1'b0, 0, p, c);
            ph[s] = p;
            step;
            checks++; if (wrap !== c) begin errors++; $display("FAIL wrap s=%0d: got %0b expected %0b", s, wrap, c); end
            if (s >= 3) begin
                e = ref_out(ph[s - 2], 2, 255);
                checks++;
                if ({pos_out, neg_out} !== e) begin
                    errors++;
                    $display("FAIL wrap_sample edge=%0d: got pos=%0d neg=%0d expected pos=%0d neg=%0d", s - 2, pos_out, neg_out, e[15:8], e[7:0]);
                end
            end
        end
        phase_clr = 1'b0; sin_clk = 1'b0;
    endtask

    task automatic test_ftw_load;
        int ex [4] = '{0, 64, 128, 255};
        setup(32'h100000, 1, 255);
        sin_clk = 1'b1;
        for (int s = 1; s <= 6; s++) begin
            ftw_load = (s == 2);
            ftw = s == 2 ? 24'h200000 : 24'h100000;
            step;
            if (s >= 3) begin
                checks++;
                if (pos_out !== 8'(ex[s - 3]) || neg_out !== 8'd0) begin
                    errors++;
                    $display("FAIL ftw_load n=%0d: got pos=%0d neg=%0d expected pos=%0d neg=0", s - 3, pos_out, neg_out, ex[s - 3]);
                end
            end
        end
        ftw_load = 1'b0; sin_clk = 1'b0;
    endtask

    task automatic test_reset_mid;
        int ep;
        setup(0, 2, 255);
        sin_clk = 1'b1;
        step; step; step; step;
        checks++; if (pos_out !== 8'd255) begin errors++; $display("FAIL rstmid_pre: got %0d expected 255", pos_out); end
        sin_clk = 1'b0;
        step;
        reset = 1'b1;
        #1;
        checks++;
        if (pos_out !== 8'd0 || neg_out !== 8'd0 || sample_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: got pos=%0d neg=%0d v=%0b expected 0 0 0", pos_out, neg_out, sample_valid);
        end
        step; step;
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL rstmid_hold: got %0b expected 0", sample_valid); end
        reset = 1'b0;
        ftw = 24'h400000; ftw_load = 1'b1;
        step;
        ftw_load = 1'b0; sin_clk = 1'b1;
        for (int s = 1; s <= 5; s++) begin
            step;
            if (s < 3) begin
                checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL rstmid_flush s=%0d: got %0b expected 0", s, sample_valid); end
            end else begin
                ep = s < 5 ? 255 : 0;
                checks++;
                if (sample_valid !== 1'b1 || pos_out !== 8'(ep) || neg_out !== 8'(255 - ep)) begin
                    errors++;
                    $display("FAIL rstmid_restart n=%0d: got v=%0b pos=%0d neg=%0d expected v=1 pos=%0d neg=%0d",
                             s - 3, sample_valid, pos_out, neg_out, ep, 255 - ep);
                end
            end
        end
        sin_clk = 1'b0;
    endtask

    task automatic test_random;
        bit          ev [302];
        logic [15:0] eo [302];
        logic [15:0] last;
        int p, e;
        bit c;
        sin_clk = 1'b0; ftw_load = 1'b0; phase_clr = 1'b0;
        reset = 1'b1;
        step;
        reset = 1'b0;
        m_acc = 0; m_ftw = 0; last = '0;
        for (int s = 1; s <= 300; s++) begin
            sin_clk   = ($urandom % 4) != 0;
            phase_clr = ($urandom % 16) == 0;
            ftw_load  = ($urandom % 8) == 0;
            ftw       = 24'($urandom);
            wave_sel  = 2'($urandom);
            amp       = ($urandom % 4 == 0) ? 8'd255 : 8'($urandom);
            model_tick(sin_clk, phase_clr, ftw_load, int'(ftw), p, c);
            ev[s] = sin_clk;
            eo[s] = sin_clk ? ref_out(p, int'(wave_sel), int'(amp)) : 16'd0;
            step;
            checks++; if (wrap !== c) begin errors++; $display("FAIL rand_wrap s=%0d: got %0b expected %0b", s, wrap, c); end
            e = s - 2;
            if (e >= 1 && ev[e]) last = eo[e];
            checks++;
            if (sample_valid !== (e >= 1 && ev[e]) || {pos_out, neg_out} !== last) begin
                errors++;
                $display("FAIL rand_out s=%0d: got v=%0b pos=%0d neg=%0d expected v=%0b pos=%0d neg=%0d",
                         s, sample_valid, pos_out, neg_out, e >= 1 && ev[e], last[15:8], last[7:0]);
            end
        end
        sin_clk = 1'b0; ftw_load = 1'b0; phase_clr = 1'b0;
    endtask

    initial begin
        test_reset;
        test_square;
        test_triangle;
        test_sine;
        test_amp;
        test_wrap_clear;
        test_ftw_load;
        test_reset_mid;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
